vc_arbiter_fsm: RTL and testbench

//  Controller/arbiter for the two-class switch datapath. Drains two virtual-channel

---
 rtl/vc_arbiter_fsm_pkg.sv | 22 ++
 rtl/vc_starve_arb.sv | 47 ++++
 rtl/vc_arbiter_fsm.sv | 104 ++++++++++
 tb/tb_vc_arbiter_fsm.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_arbiter_fsm_pkg.sv
// Shared definitions for the two-class VC arbiter: word layout, widths and FSM states.
package vc_arbiter_fsm_pkg;

    localparam int DATA_SIZE  = 10;
    localparam int MAX_CONSEC = 3;
    localparam int THR_W      = 3;
    localparam int ERR_W      = 4;

    // Route bit sits just below the class bit at the top of the word.
    localparam int ROUTE_BIT  = DATA_SIZE - 2;

    localparam int CNT_W      = $clog2(MAX_CONSEC + 1);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

endpackage

// File: rtl/vc_starve_arb.sv
// Two-way grant logic that favours VC0 but forces a VC1 grant after MAX_CONSEC
// back-to-back VC0 grants while VC1 was waiting.
module vc_starve_arb
    import vc_arbiter_fsm_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic elig0,
    input  logic elig1,
    output logic gnt0,
    output logic gnt1
);

    logic [CNT_W-1:0] starve_cnt;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (elig0 && elig1) begin
            if (starve_cnt == CNT_W'(MAX_CONSEC))
                gnt1 = 1'b1;
            else
                gnt0 = 1'b1;
        end else begin
            gnt0 = elig0;
            gnt1 = elig1;
        end
    end

    // The counter only moves when a grant is actually taken; idle cycles leave it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (en) begin
            if (gnt1) begin
                starve_cnt <= '0;
            end else if (gnt0) begin
                if (!elig1)
                    starve_cnt <= '0;
                else if (starve_cnt != CNT_W'(MAX_CONSEC))
                    starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vc_arbiter_fsm.sv
// Drains two virtual-channel FIFOs into two destination FIFOs chosen by each word's
// route bit, with almost-full backpressure, threshold programming and sticky error.
module vc_arbiter_fsm
    import vc_arbiter_fsm_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [THR_W-1:0]     thr_af_in,
    input  logic [THR_W-1:0]     thr_ae_in,
    output logic [THR_W-1:0]     thr_af,
    output logic [THR_W-1:0]     thr_ae,
    input  logic                 vc0_empty,
    input  logic                 vc1_empty,
    input  logic [DATA_SIZE-1:0] vc0_data,
    input  logic [DATA_SIZE-1:0] vc1_data,
    output logic                 vc0_pop,
    output logic                 vc1_pop,
    input  logic                 d0_almost_full,
    input  logic                 d1_almost_full,
    output logic                 d0_push,
    output logic                 d1_push,
    output logic [DATA_SIZE-1:0] d_data,
    input  logic [ERR_W-1:0]     fifo_err,
    output logic [2:0]           state,
    output logic                 idle,
    output logic                 error_out
);

    state_t               cur;
    logic                 active;
    logic                 elig0;
    logic                 elig1;
    logic                 gnt0;
    logic                 gnt1;
    logic                 any_pop;
    logic [DATA_SIZE-1:0] pop_word;

    // Reset masks the pops so a word is never removed in a cycle whose push gets dropped.
    assign active = (cur == ST_ACTIVE) && !reset;

    assign elig0 = !vc0_empty &&
                   !(vc0_data[ROUTE_BIT] ? d1_almost_full : d0_almost_full);
    assign elig1 = !vc1_empty &&
                   !(vc1_data[ROUTE_BIT] ? d1_almost_full : d0_almost_full);

    vc_starve_arb u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (active),
        .elig0 (elig0),
        .elig1 (elig1),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    assign vc0_pop  = active && gnt0;
    assign vc1_pop  = active && gnt1;
    assign any_pop  = vc0_pop || vc1_pop;
    assign pop_word = vc1_pop ? vc1_data : vc0_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur     <= ST_RESET;
            thr_af  <= '0;
            thr_ae  <= '0;
            d0_push <= 1'b0;
            d1_push <= 1'b0;
            d_data  <= '0;
        end else begin
            d0_push <= any_pop && !pop_word[ROUTE_BIT];
            d1_push <= any_pop &&  pop_word[ROUTE_BIT];
            if (any_pop)
                d_data <= pop_word;

            if (cur == ST_INIT) begin
                thr_af <= thr_af_in;
                thr_ae <= thr_ae_in;
            end

            // ERROR is absorbing; elsewhere a FIFO error outranks init, which outranks flow.
            if (cur != ST_ERROR) begin
                if (|fifo_err) begin
                    cur <= ST_ERROR;
                end else if (init) begin
                    cur <= ST_INIT;
                end else begin
                    case (cur)
                        ST_RESET:  cur <= ST_INIT;
                        ST_INIT:   cur <= ST_IDLE;
                        ST_IDLE:   if (!vc0_empty || !vc1_empty) cur <= ST_ACTIVE;
                        ST_ACTIVE: if (vc0_empty && vc1_empty)   cur <= ST_IDLE;
                        default:   cur <= cur;
                    endcase
                end
            end
        end
    end

    assign state     = cur;
    assign idle      = (cur == ST_IDLE) && vc0_empty && vc1_empty;
    assign error_out = (cur == ST_ERROR);

endmodule

// File: tb/tb_vc_arbiter_fsm.sv
// Directed plus randomized checks of vc_arbiter_fsm against a queue-based behavioural model.
module tb_vc_arbiter_fsm;
    import vc_arbiter_fsm_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 init = 1'b0;
    logic [THR_W-1:0]     thr_af_in = '0;
    logic [THR_W-1:0]     thr_ae_in = '0;
    logic [THR_W-1:0]     thr_af;
    logic [THR_W-1:0]     thr_ae;
    logic                 vc0_empty = 1'b1;
    logic                 vc1_empty = 1'b1;
    logic [DATA_SIZE-1:0] vc0_data = '0;
    logic [DATA_SIZE-1:0] vc1_data = '0;
    logic                 vc0_pop;
    logic                 vc1_pop;
    logic                 d0_almost_full = 1'b0;
    logic                 d1_almost_full = 1'b0;
    logic                 d0_push;
    logic                 d1_push;
    logic [DATA_SIZE-1:0] d_data;
    logic [ERR_W-1:0]     fifo_err = '0;
    logic [2:0]           state;
    logic                 idle;
    logic                 error_out;

    always #5 clk = ~clk;

    vc_arbiter_fsm dut (
        .clk            (clk),
        .reset          (reset),
        .init           (init),
        .thr_af_in      (thr_af_in),
        .thr_ae_in      (thr_ae_in),
        .thr_af         (thr_af),
        .thr_ae         (thr_ae),
        .vc0_empty      (vc0_empty),
        .vc1_empty      (vc1_empty),
        .vc0_data       (vc0_data),
        .vc1_data       (vc1_data),
        .vc0_pop        (vc0_pop),
        .vc1_pop        (vc1_pop),
        .d0_almost_full (d0_almost_full),
        .d1_almost_full (d1_almost_full),
        .d0_push        (d0_push),
        .d1_push        (d1_push),
        .d_data         (d_data),
        .fifo_err       (fifo_err),
        .state          (state),
        .idle           (idle),
        .error_out      (error_out)
    );

    int total = 0;
    int bad   = 0;

    // Model of the source FIFO contents and of the block's observable behaviour.
    logic [DATA_SIZE-1:0] q0[$];
    logic [DATA_SIZE-1:0] q1[$];
    int                   grant_log[$];
    int                   m_state = 0;
    int                   m_consec = 0;
    logic [THR_W-1:0]     m_af = '0;
    logic [THR_W-1:0]     m_ae = '0;
    logic                 m_p0 = 1'b0;
    logic                 m_p1 = 1'b0;
    logic [DATA_SIZE-1:0] m_data = '0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic driveVc();
        vc0_empty = (q0.size() == 0);
        vc1_empty = (q1.size() == 0);
        vc0_data  = vc0_empty ? '0 : q0[0];
        vc1_data  = vc1_empty ? '0 : q1[0];
    endtask

    function automatic logic headOk(input logic [DATA_SIZE-1:0] w);
        return w[ROUTE_BIT] ? !d1_almost_full : !d0_almost_full;
    endfunction

    // One clock cycle: drive, check pops, advance model, check registered outputs.
    task automatic applyStimulus(input logic rst, input logic in_init, input logic [ERR_W-1:0] err);
        logic                 e0, e1, g0, g1;
        logic [DATA_SIZE-1:0] w;
        logic                 was_empty;
        reset    = rst;
        init     = in_init;
        fifo_err = err;
        driveVc();
        #3;
        e0 = 1'b0;
        e1 = 1'b0;
        if (q0.size() > 0) begin w = q0[0]; e0 = headOk(w); end
        if (q1.size() > 0) begin w = q1[0]; e1 = headOk(w); end
        g0 = 1'b0;
        g1 = 1'b0;
        if (m_state == 3 && !rst) begin
            if (e0 && e1) begin
                if (m_consec >= MAX_CONSEC) g1 = 1'b1; else g0 = 1'b1;
            end else begin
                g0 = e0;
                g1 = e1;
            end
        end
        checkOutput("vc0_pop", 32'(vc0_pop), 32'(g0));
        checkOutput("vc1_pop", 32'(vc1_pop), 32'(g1));
        if (vc0_pop || vc1_pop) grant_log.push_back(vc1_pop ? 1 : 0);
        was_empty = (q0.size() == 0) && (q1.size() == 0);

        @(posedge clk);
        if (rst) begin
            m_state  = 0;
            m_consec = 0;
            m_af     = '0;
            m_ae     = '0;
            m_p0     = 1'b0;
            m_p1     = 1'b0;
            m_data   = '0;
        end else begin
            m_p0 = 1'b0;
            m_p1 = 1'b0;
            if (g0 || g1) begin
                w = g1 ? q1.pop_front() : q0.pop_front();
                m_data = w;
                if (w[ROUTE_BIT]) m_p1 = 1'b1; else m_p0 = 1'b1;
            end
            if (g1) m_consec = 0;
            else if (g0) m_consec = e1 ? ((m_consec < MAX_CONSEC) ? m_consec + 1 : MAX_CONSEC) : 0;
            if (m_state == 1) begin
                m_af = thr_af_in;
                m_ae = thr_ae_in;
            end
            if (m_state != 4) begin
                if (err != 0)       m_state = 4;
                else if (in_init)   m_state = 1;
                else if (m_state == 0) m_state = 1;
                else if (m_state == 1) m_state = 2;
                else if (m_state == 2 && !was_empty) m_state = 3;
                else if (m_state == 3 && was_empty)  m_state = 2;
            end
        end
        #1;
        driveVc();
        #1;
        checkOutput("state",     32'(state),     32'(m_state));
        checkOutput("d0_push",   32'(d0_push),   32'(m_p0));
        checkOutput("d1_push",   32'(d1_push),   32'(m_p1));
        checkOutput("d_data",    32'(d_data),    32'(m_data));
        checkOutput("thr_af",    32'(thr_af),    32'(m_af));
        checkOutput("thr_ae",    32'(thr_ae),    32'(m_ae));
        checkOutput("error_out", 32'(error_out), 32'(m_state == 4));
        checkOutput("idle",      32'(idle),
                    32'(m_state == 2 && q0.size() == 0 && q1.size() == 0));
    endtask

    initial begin
        int pattern[8];
        logic [DATA_SIZE-1:0] w;
        pattern = '{0, 0, 0, 1, 0, 0, 0, 1};
        @(posedge clk);
        #1;

        $display("[TB] reset and threshold programming");
        applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, '0);
        thr_af_in = 3'd6;
        thr_ae_in = 3'd1;
        applyStimulus(1'b0, 1'b1, '0);
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("thr_af_prog", 32'(thr_af), 32'd6);
        checkOutput("thr_ae_prog", 32'(thr_ae), 32'd1);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("idle_after_init", 32'(idle), 32'd1);

        $display("[TB] VC0 two-word drain");
        q0.push_back(10'h0FF);
        q0.push_back(10'h0EE);
        repeat (5) applyStimulus(1'b0, 1'b0, '0);

        $display("[TB] VC1 single word to D1");
        q1.push_back(10'h3DD);
        repeat (4) applyStimulus(1'b0, 1'b0, '0);

        $display("[TB] starvation pattern");
        grant_log.delete();
        for (int i = 0; i < 8; i++) q0.push_back(DATA_SIZE'(10'h010 + i));
        for (int i = 0; i < 4; i++) q1.push_back(DATA_SIZE'(10'h200 + i));
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 1'b0, '0);
            if (q0.size() == 0 && q1.size() == 0 && m_state == 2) break;
        end
        checkOutput("grant_count", 32'(grant_log.size() >= 8), 32'd1);
        for (int i = 0; i < 8; i++)
            checkOutput("grant_seq", (grant_log.size() > i) ? 32'(grant_log[i]) : 32'hDEAD,
                        32'(pattern[i]));

        $display("[TB] almost-full backpressure");
        d0_almost_full = 1'b1;
        q0.push_back(10'h0BB);
        q1.push_back(10'h399);
        applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, '0);
        d0_almost_full = 1'b0;
        repeat (3) applyStimulus(1'b0, 1'b0, '0);

        $display("[TB] sticky error");
        for (int i = 0; i < 4; i++) q0.push_back(DATA_SIZE'(10'h040 + i));
        applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 4'b0010);
        checkOutput("error_flag", 32'(error_out), 32'd1);
        thr_af_in = 3'd3;
        thr_ae_in = 3'd2;
        repeat (3) applyStimulus(1'b0, 1'b1, '0);
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("reset_from_error", 32'(state), 32'd0);
        applyStimulus(1'b0, 1'b1, '0);
        applyStimulus(1'b0, 1'b0, '0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 300; i++) begin
            if (q0.size() < 8 && $urandom_range(0, 2) == 0) begin
                w = DATA_SIZE'($urandom);
                w[DATA_SIZE-1] = 1'b0;
                q0.push_back(w);
            end
            if (q1.size() < 8 && $urandom_range(0, 2) == 0) begin
                w = DATA_SIZE'($urandom);
                w[DATA_SIZE-1] = 1'b1;
                q1.push_back(w);
            end
            d0_almost_full = ($urandom_range(0, 3) == 0);
            d1_almost_full = ($urandom_range(0, 3) == 0);
            thr_af_in = THR_W'($urandom);
            thr_ae_in = THR_W'($urandom);
            applyStimulus(1'b0, ($urandom_range(0, 29) == 0), '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
